alu_seq_param: RTL

//   Parametrised multi-cycle ALU for the AP9 datapath; successor to the 16-bit ALU.

---
 rtl/alu_seq_param.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - parametrised multi-cycle ALU with start/busy/done handshake
//
// Purpose: executes the AP9 arithmetic/logic opcode set on WIDTH-bit operands.
//   Single-cycle ops finish two edges after the accepting edge. Iterative multiply
//   and restoring divide/modulo take WIDTH additional edges.
// Ports:
//   wire_clock  clock, rising edge
//   reset       synchronous active-high reset
//   start       request, accepted while idle (including the done cycle)
//   op_code     6-bit opcode
//   operand_a   first operand
//   operand_b   second operand / shift amount
//   fr_in       current flag register (bit 11 is carry-in)
//   use_carry   add/sub include carry/borrow
//   dec         inc/dec select (1 = decrement)
//   shift_mode  [2:1] selects shl/shr/rotl/rotr
//   result      registered result
//   fr_out      registered flags
//   busy        high from the accepting edge through the done cycle
//   done        one-cycle completion pulse
module alu_seq_param #(
  parameter int WIDTH         = 16,
  parameter int MUL_ITERATIVE = 1
) (
  input  logic             wire_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op_code,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [15:0]      fr_in,
  input  logic             use_carry,
  input  logic             dec,
  input  logic [2:0]       shift_mode,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      fr_out,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100001;
  localparam logic [5:0] OP_MUL   = 6'b100010;
  localparam logic [5:0] OP_DIV   = 6'b100011;
  localparam logic [5:0] OP_INC   = 6'b100100;
  localparam logic [5:0] OP_MOD   = 6'b100101;
  localparam logic [5:0] OP_CMP   = 6'b010110;
  localparam logic [5:0] OP_AND   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_XOR   = 6'b010100;
  localparam logic [5:0] OP_NOT   = 6'b010101;
  localparam logic [5:0] OP_SHIFT = 6'b010000;
  localparam logic [5:0] OP_LDF   = 6'b000110;

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [15:0]        frin_q, frin_d;
  logic               uc_q, uc_d, dec_q, dec_d;
  logic [1:0]         sm_q, sm_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [15:0]        fr_q, fr_d;
  logic               busy_q, busy_d, done_q, done_d;
  // Shared iteration register: multiply keeps {partial product, multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Only shift_mode[2:1] selects the operation.
  logic unused_shift_lsb;
  assign unused_shift_lsb = shift_mode[0];

  logic               cin;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rot_amt, shl_v, shr_v, rotl_v, rotr_v;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign cin      = uc_q & frin_q[11];
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
  // Top bit set means the subtraction went negative (borrow).
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
  assign prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  assign rot_amt = b_q % W_V;
  assign shl_v   = (b_q >= W_V) ? '0 : (a_q << b_q);
  assign shr_v   = (b_q >= W_V) ? '0 : (a_q >> b_q);
  // A shift by WIDTH yields zero, so amount 0 returns a unchanged.
  assign rotl_v  = (a_q << rot_amt) | (a_q >> (W_V - rot_amt));
  assign rotr_v  = (a_q >> rot_amt) | (a_q << (W_V - rot_amt));

  // Shift-add step: add b into the upper half when the multiplier LSB is set,
  // then shift the whole register right by one.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring-divide step; the remainder stays below b so WIDTH bits suffice.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    frin_d   = frin_q;
    uc_d     = uc_q;
    dec_d    = dec_q;
    sm_d     = sm_q;
    result_d = result_q;
    fr_d     = fr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d    = op_code;
          a_d     = operand_a;
          b_d     = operand_b;
          frin_d  = fr_in;
          uc_d    = use_carry;
          dec_d   = dec;
          sm_d    = shift_mode[2:1];
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          OP_ADD: begin
            result_d  = add_sum[WIDTH-1:0];
            fr_d[11]  = add_sum[WIDTH];
            fr_d[12]  = (add_sum[WIDTH-1:0] == '0);
          end
          OP_SUB: begin
            if (sub_diff[WIDTH]) begin
              result_d = '0;
              fr_d[6]  = 1'b1;
              fr_d[12] = 1'b1;
            end else begin
              result_d = sub_diff[WIDTH-1:0];
              fr_d[6]  = 1'b0;
              fr_d[12] = (sub_diff[WIDTH-1:0] == '0);
            end
          end
          OP_MUL: begin
            if (MUL_ITERATIVE != 0) begin
              acc_d   = {{WIDTH{1'b0}}, a_q};
              cnt_d   = '0;
              state_d = S_ITER;
            end else begin
              result_d = prod[WIDTH-1:0];
              fr_d[10] = (prod[2*WIDTH-1:WIDTH] != '0);
            end
          end
          OP_DIV, OP_MOD: begin
            if (b_q == '0) begin
              fr_d[9] = 1'b1;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_q};
              cnt_d   = '0;
              state_d = S_ITER;
            end
          end
          OP_INC:   result_d = dec_q ? (a_q - WIDTH'(1)) : (a_q + WIDTH'(1));
          OP_CMP:   fr_d[15:13] = {a_q == b_q, a_q < b_q, a_q > b_q};
          OP_AND: begin
            result_d = a_q & b_q;
            fr_d[12] = ((a_q & b_q) == '0);
          end
          OP_OR: begin
            result_d = a_q | b_q;
            fr_d[12] = ((a_q | b_q) == '0);
          end
          OP_XOR: begin
            result_d = a_q ^ b_q;
            fr_d[12] = ((a_q ^ b_q) == '0);
          end
          OP_NOT: begin
            result_d = ~a_q;
            fr_d[12] = (~a_q == '0);
          end
          OP_SHIFT: begin
            case (sm_q)
              2'b00:   result_d = shl_v;
              2'b01:   result_d = shr_v;
              2'b10:   result_d = rotl_v;
              default: result_d = rotr_v;
            endcase
          end
          OP_LDF:  fr_d = frin_q;
          default: ;
        endcase
      end

      S_ITER: begin
        acc_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          if (op_q == OP_MUL) begin
            result_d = mul_next[WIDTH-1:0];
            fr_d[10] = (mul_next[2*WIDTH-1:WIDTH] != '0);
          end else if (op_q == OP_DIV) begin
            result_d = div_next[WIDTH-1:0];
            fr_d[9]  = 1'b0;
          end else begin
            result_d = div_next[2*WIDTH-1:WIDTH];
            fr_d[9]  = 1'b0;
          end
        end
      end

      default: begin
        // Done cycle follows; busy stays high through it.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wire_clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      frin_q   <= '0;
      uc_q     <= 1'b0;
      dec_q    <= 1'b0;
      sm_q     <= '0;
      result_q <= '0;
      fr_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      frin_q   <= frin_d;
      uc_q     <= uc_d;
      dec_q    <= dec_d;
      sm_q     <= sm_d;
      result_q <= result_d;
      fr_q     <= fr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign fr_out = fr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
